// File: rtl/ap_status_monitor_if.sv
`default_nettype none
// ============================================================================
// ap_status_monitor_if : handshake, control and readback bundle for the monitor
// Rev 1.0
// ============================================================================
interface ap_status_monitor_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) ();
  logic [NUM_CH-1:0] ap_start;
  logic [NUM_CH-1:0] ap_ready;
  logic [NUM_CH-1:0] ap_done;
  logic [NUM_CH-1:0] ap_continue;
  logic              finish;
  logic              clear;
  logic [SEL_W-1:0]  rd_sel;
  logic [2:0]        rd_field;
  logic [CNT_W-1:0]  rd_data;
  logic [NUM_CH-1:0] busy;
  logic              frozen;

  modport master (
    output ap_start, ap_ready, ap_done, ap_continue, finish, clear, rd_sel, rd_field,
    input  rd_data, busy, frozen
  );

  modport slave (
    input  ap_start, ap_ready, ap_done, ap_continue, finish, clear, rd_sel, rd_field,
    output rd_data, busy, frozen
  );
endinterface
`default_nettype wire

// File: rtl/ap_status_monitor.sv
`default_nettype none
// ============================================================================
// ap_status_monitor : per-channel ap_start/ap_done/ap_continue statistics
// Rev 1.0
// ============================================================================
module ap_status_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int SEL_W  = 4
) (
  input  logic               clk,
  input  logic               rst,
  ap_status_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] C_ZERO = '0;
  localparam logic [CNT_W-1:0] C_ONES = '1;
  localparam logic [CNT_W-1:0] C_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           state_q [NUM_CH];
  state_t           state_d [NUM_CH];
  logic [CNT_W-1:0] lat_q   [NUM_CH];
  logic [CNT_W-1:0] lat_d   [NUM_CH];
  logic [CNT_W-1:0] txn_q   [NUM_CH];
  logic [CNT_W-1:0] txn_d   [NUM_CH];
  logic [CNT_W-1:0] last_q  [NUM_CH];
  logic [CNT_W-1:0] last_d  [NUM_CH];
  logic [CNT_W-1:0] min_q   [NUM_CH];
  logic [CNT_W-1:0] min_d   [NUM_CH];
  logic [CNT_W-1:0] max_q   [NUM_CH];
  logic [CNT_W-1:0] max_d   [NUM_CH];
  logic [CNT_W-1:0] stall_q [NUM_CH];
  logic [CNT_W-1:0] stall_d [NUM_CH];
  logic [CNT_W-1:0] ready_q [NUM_CH];
  logic [CNT_W-1:0] ready_d [NUM_CH];
  logic [NUM_CH-1:0] busy_q, busy_d;
  logic              frozen_q, frozen_d;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == C_ONES) ? v : v + C_ONE;
  endfunction

  always_comb begin : p_next
    logic             comp;
    logic [CNT_W-1:0] lat_v;
    comp     = 1'b0;
    lat_v    = C_ZERO;
    busy_d   = '0;
    frozen_d = bus.clear ? 1'b0 : (frozen_q | bus.finish);
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      lat_d[c]   = lat_q[c];
      txn_d[c]   = txn_q[c];
      last_d[c]  = last_q[c];
      min_d[c]   = min_q[c];
      max_d[c]   = max_q[c];
      stall_d[c] = stall_q[c];
      ready_d[c] = ready_q[c];
      comp       = 1'b0;
      lat_v      = lat_q[c];
      // lat_v is the start-to-first-done latency reported if this cycle completes
      case (state_q[c])
        ST_IDLE: begin
          if (bus.ap_start[c]) begin
            lat_d[c] = C_ZERO;
            lat_v    = C_ZERO;
            if (bus.ap_done[c]) begin
              if (bus.ap_continue[c]) comp = 1'b1;
              else                    state_d[c] = ST_HOLD;
            end else begin
              state_d[c] = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          lat_v    = sat_inc(lat_q[c]);
          lat_d[c] = lat_v;
          if (bus.ap_done[c]) begin
            if (bus.ap_continue[c]) begin
              comp       = 1'b1;
              state_d[c] = ST_IDLE;
            end else begin
              state_d[c] = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.ap_continue[c]) begin
            comp       = 1'b1;
            state_d[c] = ST_IDLE;
          end else if (!frozen_q) begin
            stall_d[c] = sat_inc(stall_q[c]);
          end
        end
        default: state_d[c] = ST_IDLE;
      endcase
      if (comp && !frozen_q) begin
        txn_d[c]  = sat_inc(txn_q[c]);
        last_d[c] = lat_v;
        if (lat_v < min_q[c]) min_d[c] = lat_v;
        if (lat_v > max_q[c]) max_d[c] = lat_v;
      end
      if (bus.ap_ready[c] && !frozen_q) ready_d[c] = sat_inc(ready_q[c]);
      if (bus.clear) begin
        state_d[c] = ST_IDLE;
        lat_d[c]   = C_ZERO;
        txn_d[c]   = C_ZERO;
        last_d[c]  = C_ZERO;
        min_d[c]   = C_ONES;
        max_d[c]   = C_ZERO;
        stall_d[c] = C_ZERO;
        ready_d[c] = C_ZERO;
      end
      busy_d[c] = (state_d[c] != ST_IDLE);
    end
  end

  // Unmatched rd_sel values and field 7 fall through to zero
  always_comb begin : p_read
    rd_data_d = C_ZERO;
    for (int c = 0; c < NUM_CH; c++) begin
      if (bus.rd_sel == c[SEL_W-1:0]) begin
        case (bus.rd_field)
          3'd0:    rd_data_d = txn_q[c];
          3'd1:    rd_data_d = last_q[c];
          3'd2:    rd_data_d = (txn_q[c] == C_ZERO) ? C_ZERO : min_q[c];
          3'd3:    rd_data_d = max_q[c];
          3'd4:    rd_data_d = stall_q[c];
          3'd5:    rd_data_d = ready_q[c];
          3'd6:    rd_data_d = {{(CNT_W-2){1'b0}}, state_q[c]};
          default: rd_data_d = C_ZERO;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= ST_IDLE;
        lat_q[c]   <= C_ZERO;
        txn_q[c]   <= C_ZERO;
        last_q[c]  <= C_ZERO;
        min_q[c]   <= C_ONES;
        max_q[c]   <= C_ZERO;
        stall_q[c] <= C_ZERO;
        ready_q[c] <= C_ZERO;
      end
      busy_q    <= '0;
      frozen_q  <= 1'b0;
      rd_data_q <= C_ZERO;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      txn_q     <= txn_d;
      last_q    <= last_d;
      min_q     <= min_d;
      max_q     <= max_d;
      stall_q   <= stall_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      frozen_q  <= frozen_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.rd_data = rd_data_q;
  assign bus.busy    = busy_q;
  assign bus.frozen  = frozen_q;

endmodule
`default_nettype wire
